// File: rtl/axi_lite_led_bank_pkg.sv
// Shared encodings for the AXI4-Lite LED/GPIO bank: write modes, response codes
// and the write/read FSM states.
package axi_lite_led_bank_pkg;

    typedef enum logic [1:0] {
        MODE_WRITE  = 2'd0,
        MODE_SET    = 2'd1,
        MODE_CLEAR  = 2'd2,
        MODE_TOGGLE = 2'd3
    } mode_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic {
        W_IDLE = 1'b0,
        W_RESP = 1'b1
    } wstate_e;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } rstate_e;

endpackage

// File: rtl/led_bank_lane.sv
// One output channel register: applies WRITE/SET/CLEAR/TOGGLE under a per-byte
// strobe mask when the commit pulse is high.
module led_bank_lane
    import axi_lite_led_bank_pkg::*;
#(
    parameter int CH_WIDTH   = 8,
    parameter int STRB_WIDTH = 4
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  i_commit,
    input  mode_e                 i_mode,
    input  logic [CH_WIDTH-1:0]   i_data,
    input  logic [STRB_WIDTH-1:0] i_strb,
    output logic [CH_WIDTH-1:0]   o_value
);

    logic [CH_WIDTH-1:0] r_value;
    logic [CH_WIDTH-1:0] w_mask;
    logic [CH_WIDTH-1:0] w_op;
    logic [CH_WIDTH-1:0] w_next;
    logic                w_unused;

    // Bit i of the register belongs to byte lane i/8.
    for (genvar gi = 0; gi < CH_WIDTH; gi++) begin : g_mask
        assign w_mask[gi] = i_strb[gi/8];
    end

    assign w_unused = &{1'b0, i_strb};

    // Mode operation on the whole register, then merged through the strobe mask.
    always_comb begin
        w_op = r_value;
        case (i_mode)
            MODE_WRITE:  w_op = i_data;
            MODE_SET:    w_op = r_value | i_data;
            MODE_CLEAR:  w_op = r_value & ~i_data;
            MODE_TOGGLE: w_op = r_value ^ i_data;
            default:     w_op = r_value;
        endcase
        w_next = (w_op & w_mask) | (r_value & ~w_mask);
    end

    // Channel register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_value <= '0;
        end else if (i_commit) begin
            r_value <= w_next;
        end
    end

    assign o_value = r_value;

endmodule

// File: rtl/axi_lite_led_bank.sv
// AXI4-Lite slave owning NUM_CH output registers with SET/CLEAR/TOGGLE aliases,
// independent AW/W capture and SLVERR on decode errors; drives a flat LED bus.
module axi_lite_led_bank
    import axi_lite_led_bank_pkg::*;
#(
    parameter int NUM_CH     = 4,
    parameter int CH_WIDTH   = 8,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 12
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic                       s_awvalid,
    input  logic [ADDR_WIDTH-1:0]      s_awaddr,
    output logic                       s_awready,
    input  logic [DATA_WIDTH-1:0]      s_wdata,
    input  logic [DATA_WIDTH/8-1:0]    s_wstrb,
    input  logic                       s_wvalid,
    output logic                       s_wready,
    output logic [1:0]                 s_bresp,
    output logic                       s_bvalid,
    input  logic                       s_bready,
    input  logic                       s_arvalid,
    input  logic [ADDR_WIDTH-1:0]      s_araddr,
    output logic                       s_arready,
    output logic [DATA_WIDTH-1:0]      s_rdata,
    output logic [1:0]                 s_rresp,
    output logic                       s_rvalid,
    input  logic                       s_rready,
    output logic [NUM_CH*CH_WIDTH-1:0] LED
);

    localparam int CH_BITS = $clog2(NUM_CH);
    localparam int STRB_W  = DATA_WIDTH / 8;
    localparam int HI_BIT  = 4 + CH_BITS;
    localparam logic [CH_BITS:0] NUM_CH_L = (CH_BITS + 1)'(NUM_CH);

    // Anything above the mode field, or a channel beyond NUM_CH, is unmapped.
    function automatic logic addr_err(input logic [ADDR_WIDTH-1:0] a);
        logic [CH_BITS:0] ch_ext;
        ch_ext = {1'b0, a[2 +: CH_BITS]};
        return ((a >> HI_BIT) != '0) || (ch_ext >= NUM_CH_L);
    endfunction

    wstate_e               r_wstate;
    wstate_e               w_wstate_nxt;
    logic                  r_aw_held;
    logic                  r_w_held;
    logic                  w_aw_held_nxt;
    logic                  w_w_held_nxt;
    logic                  r_awready;
    logic                  r_wready;
    logic [ADDR_WIDTH-1:0] r_awaddr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [STRB_W-1:0]     r_wstrb;
    logic                  r_bvalid;
    logic [1:0]            r_bresp;

    logic                  w_aw_fire;
    logic                  w_w_fire;
    logic                  w_have_aw;
    logic                  w_have_w;
    logic                  w_commit;
    logic [ADDR_WIDTH-1:0] w_waddr;
    logic [DATA_WIDTH-1:0] w_wdata;
    logic [STRB_W-1:0]     w_wstrb;
    logic                  w_wr_err;
    logic [CH_BITS-1:0]    w_wr_ch;
    mode_e                 w_wr_mode;

    rstate_e               r_rstate;
    logic                  r_arready;
    logic                  r_rvalid;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic [1:0]            r_rresp;
    logic                  w_ar_fire;
    logic                  w_rd_err;
    logic [CH_BITS-1:0]    w_rd_ch;
    logic [CH_WIDTH-1:0]   w_rd_val;

    logic [CH_WIDTH-1:0]   w_ch_val [NUM_CH];
    logic [NUM_CH-1:0]     w_lane_commit;
    logic                  w_unused;

    assign w_unused = &{1'b0, s_araddr, w_waddr, w_wdata};

    // Write path: pick held or live AW/W, decide commit and next handshake state.
    always_comb begin
        w_aw_fire     = s_awvalid & r_awready;
        w_w_fire      = s_wvalid & r_wready;
        w_have_aw     = r_aw_held | w_aw_fire;
        w_have_w      = r_w_held | w_w_fire;
        w_commit      = (r_wstate == W_IDLE) & w_have_aw & w_have_w;
        w_waddr       = r_aw_held ? r_awaddr : s_awaddr;
        w_wdata       = r_w_held ? r_wdata : s_wdata;
        w_wstrb       = r_w_held ? r_wstrb : s_wstrb;
        w_wr_err      = addr_err(w_waddr);
        w_wr_ch       = w_waddr[2 +: CH_BITS];
        w_wr_mode     = mode_e'(w_waddr[2+CH_BITS +: 2]);
        w_wstate_nxt  = r_wstate;
        w_aw_held_nxt = r_aw_held;
        w_w_held_nxt  = r_w_held;
        case (r_wstate)
            W_IDLE: begin
                w_aw_held_nxt = w_have_aw;
                w_w_held_nxt  = w_have_w;
                if (w_commit) begin
                    w_wstate_nxt = W_RESP;
                end else begin
                    w_wstate_nxt = W_IDLE;
                end
            end
            W_RESP: begin
                if (s_bready) begin
                    w_wstate_nxt  = W_IDLE;
                    w_aw_held_nxt = 1'b0;
                    w_w_held_nxt  = 1'b0;
                end else begin
                    w_wstate_nxt  = W_RESP;
                end
            end
            default: begin
                w_wstate_nxt  = W_IDLE;
                w_aw_held_nxt = 1'b0;
                w_w_held_nxt  = 1'b0;
            end
        endcase
    end

    // Write FSM state, held AW/W beats, registered readies and B response.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_wstate  <= W_IDLE;
            r_aw_held <= 1'b0;
            r_w_held  <= 1'b0;
            r_awready <= 1'b0;
            r_wready  <= 1'b0;
            r_awaddr  <= '0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
            r_bvalid  <= 1'b0;
            r_bresp   <= RESP_OKAY;
        end else begin
            r_wstate  <= w_wstate_nxt;
            r_aw_held <= w_aw_held_nxt;
            r_w_held  <= w_w_held_nxt;
            r_awready <= (w_wstate_nxt == W_IDLE) & ~w_aw_held_nxt;
            r_wready  <= (w_wstate_nxt == W_IDLE) & ~w_w_held_nxt;
            if (w_aw_fire) begin
                r_awaddr <= s_awaddr;
            end
            if (w_w_fire) begin
                r_wdata <= s_wdata;
                r_wstrb <= s_wstrb;
            end
            if (w_commit) begin
                r_bvalid <= 1'b1;
                r_bresp  <= w_wr_err ? RESP_SLVERR : RESP_OKAY;
            end else if ((r_wstate == W_RESP) && s_bready) begin
                r_bvalid <= 1'b0;
            end
        end
    end

    for (genvar gc = 0; gc < NUM_CH; gc++) begin : g_lane
        assign w_lane_commit[gc] = w_commit & ~w_wr_err & (w_wr_ch == CH_BITS'(gc));

        led_bank_lane #(
            .CH_WIDTH   (CH_WIDTH),
            .STRB_WIDTH (STRB_W)
        ) u_lane (
            .CLK      (CLK),
            .RST      (RST),
            .i_commit (w_lane_commit[gc]),
            .i_mode   (w_wr_mode),
            .i_data   (w_wdata[CH_WIDTH-1:0]),
            .i_strb   (w_wstrb),
            .o_value  (w_ch_val[gc])
        );

        assign LED[gc*CH_WIDTH +: CH_WIDTH] = w_ch_val[gc];
    end

    // Read decode: select the addressed channel's current (pre-commit) value.
    always_comb begin
        w_ar_fire = s_arvalid & r_arready;
        w_rd_err  = addr_err(s_araddr);
        w_rd_ch   = s_araddr[2 +: CH_BITS];
        w_rd_val  = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            w_rd_val = (w_rd_ch == CH_BITS'(c)) ? w_ch_val[c] : w_rd_val;
        end
    end

    // Read FSM: accept AR in R_IDLE, hold R beat until rready.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_rstate  <= R_IDLE;
            r_arready <= 1'b0;
            r_rvalid  <= 1'b0;
            r_rdata   <= '0;
            r_rresp   <= RESP_OKAY;
        end else begin
            case (r_rstate)
                R_IDLE: begin
                    if (w_ar_fire) begin
                        r_rstate  <= R_DATA;
                        r_arready <= 1'b0;
                        r_rvalid  <= 1'b1;
                        r_rdata   <= w_rd_err ? '0 : DATA_WIDTH'(w_rd_val);
                        r_rresp   <= w_rd_err ? RESP_SLVERR : RESP_OKAY;
                    end else begin
                        r_arready <= 1'b1;
                    end
                end
                R_DATA: begin
                    if (s_rready) begin
                        r_rstate  <= R_IDLE;
                        r_arready <= 1'b1;
                        r_rvalid  <= 1'b0;
                    end
                end
                default: begin
                    r_rstate  <= R_IDLE;
                    r_arready <= 1'b1;
                    r_rvalid  <= 1'b0;
                end
            endcase
        end
    end

    assign s_awready = r_awready;
    assign s_wready  = r_wready;
    assign s_bvalid  = r_bvalid;
    assign s_bresp   = r_bresp;
    assign s_arready = r_arready;
    assign s_rvalid  = r_rvalid;
    assign s_rdata   = r_rdata;
    assign s_rresp   = r_rresp;

endmodule

// File: tb/tb_axi_lite_led_bank.sv
// Scoreboard bench for axi_lite_led_bank: expected B/R responses are queued when
// stimulus is driven and popped when the DUT presents them.
module tb_axi_lite_led_bank;

    localparam int NUM_CH = 4;
    localparam int CH_WIDTH = 8;
    localparam int DATA_WIDTH = 32;
    localparam int ADDR_WIDTH = 12;

    logic        CLK = 1'b0;
    logic        RST;
    logic        s_awvalid, s_awready, s_wvalid, s_wready;
    logic [11:0] s_awaddr, s_araddr;
    logic [31:0] s_wdata, s_rdata;
    logic [3:0]  s_wstrb;
    logic [1:0]  s_bresp, s_rresp;
    logic        s_bvalid, s_bready, s_arvalid, s_arready, s_rvalid, s_rready;
    logic [31:0] LED;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0]  m_ch [NUM_CH];
    logic [1:0]  exp_b_q [$];
    logic [33:0] exp_r_q [$];

    axi_lite_led_bank #(
        .NUM_CH(NUM_CH), .CH_WIDTH(CH_WIDTH), .DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)
    ) dut (
        .CLK(CLK), .RST(RST),
        .s_awvalid(s_awvalid), .s_awaddr(s_awaddr), .s_awready(s_awready),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
        .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
        .s_arvalid(s_arvalid), .s_araddr(s_araddr), .s_arready(s_arready),
        .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
        .LED(LED)
    );

    always #5 CLK = ~CLK;

    function automatic logic [31:0] led_model();
        return {m_ch[3], m_ch[2], m_ch[1], m_ch[0]};
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Queue the expected B response and update the channel model.
    task automatic push_write(input logic [11:0] addr, input logic [31:0] data, input logic [3:0] strb);
        int ch;
        logic [1:0] mode;
        ch = int'(addr[3:2]);
        mode = addr[5:4];
        if (addr[11:6] != 6'd0) begin
            exp_b_q.push_back(2'b10);
        end else begin
            exp_b_q.push_back(2'b00);
            if (strb[0]) begin
                case (mode)
                    2'd0: m_ch[ch] = data[7:0];
                    2'd1: m_ch[ch] = m_ch[ch] | data[7:0];
                    2'd2: m_ch[ch] = m_ch[ch] & ~data[7:0];
                    default: m_ch[ch] = m_ch[ch] ^ data[7:0];
                endcase
            end
        end
    endtask

    task automatic push_read(input logic [11:0] addr);
        if (addr[11:6] != 6'd0) exp_r_q.push_back({2'b10, 32'h0});
        else exp_r_q.push_back({2'b00, 24'h0, m_ch[int'(addr[3:2])]});
    endtask

    // Pop the queued B response and compare, along with bvalid and LED.
    task automatic check_b(input string tag);
        logic [1:0] eb;
        eb = (exp_b_q.size() > 0) ? exp_b_q.pop_front() : 2'bxx;
        n_checks++;
        if (s_bvalid !== 1'b1 || s_bresp !== eb || LED !== led_model()) begin
            n_errors++;
            $display("FAIL %s: bvalid=%b bresp=%b LED=%h, expected bvalid=1 bresp=%b LED=%h",
                     tag, s_bvalid, s_bresp, LED, eb, led_model());
        end
    endtask

    task automatic check_r(input string tag);
        logic [33:0] er;
        er = (exp_r_q.size() > 0) ? exp_r_q.pop_front() : 34'bx;
        n_checks++;
        if (s_rvalid !== 1'b1 || {s_rresp, s_rdata} !== er) begin
            n_errors++;
            $display("FAIL %s: rvalid=%b rresp=%b rdata=%h, expected rvalid=1 rresp=%b rdata=%h",
                     tag, s_rvalid, s_rresp, s_rdata, er[33:32], er[31:0]);
        end
    endtask

    // Full write: W may lead AW by w_lead cycles; bready held low for b_delay cycles.
    task automatic write_txn(input logic [11:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             input int w_lead, input int b_delay, input string tag);
        bit aw_done, w_done, fa, fw;
        int guard;
        aw_done = 0; w_done = 0; guard = 0;
        push_write(addr, data, strb);
        s_awaddr = addr; s_wdata = data; s_wstrb = strb; s_wvalid = 1'b1;
        if (w_lead == 0) s_awvalid = 1'b1;
        for (int i = 0; i < w_lead; i++) begin
            fw = s_wvalid & s_wready;
            tick();
            if (fw) begin s_wvalid = 1'b0; w_done = 1; end
        end
        if (w_lead > 0) begin
            n_checks++;
            if (s_wready !== 1'b0 || s_awready !== 1'b1) begin
                n_errors++;
                $display("FAIL %s_wheld: wready=%b awready=%b, expected 0/1", tag, s_wready, s_awready);
            end
            s_awvalid = 1'b1;
        end
        while (!(aw_done && w_done) && guard < 20) begin
            fa = s_awvalid & s_awready;
            fw = s_wvalid & s_wready;
            tick();
            if (fa) begin s_awvalid = 1'b0; aw_done = 1; end
            if (fw) begin s_wvalid = 1'b0; w_done = 1; end
            guard++;
        end
        if (guard >= 20) begin
            n_errors++;
            $display("FAIL %s_timeout: handshakes aw=%0d w=%0d, expected both", tag, aw_done, w_done);
            s_awvalid = 1'b0; s_wvalid = 1'b0;
            void'(exp_b_q.pop_front());
            return;
        end
        check_b(tag);
        for (int i = 0; i < b_delay; i++) begin
            tick();
            n_checks++;
            if (s_bvalid !== 1'b1 || s_awready !== 1'b0) begin
                n_errors++;
                $display("FAIL %s_bhold: bvalid=%b awready=%b, expected 1/0", tag, s_bvalid, s_awready);
            end
        end
        s_bready = 1'b1;
        tick();
        s_bready = 1'b0;
        n_checks++;
        if (s_bvalid !== 1'b0 || s_awready !== 1'b1 || s_wready !== 1'b1) begin
            n_errors++;
            $display("FAIL %s_bdone: bvalid=%b awready=%b wready=%b, expected 0/1/1",
                     tag, s_bvalid, s_awready, s_wready);
        end
    endtask

    task automatic read_txn(input logic [11:0] addr, input string tag);
        bit fr;
        int guard;
        fr = 0; guard = 0;
        push_read(addr);
        s_araddr = addr; s_arvalid = 1'b1;
        while (!fr && guard < 20) begin
            fr = s_arvalid & s_arready;
            tick();
            guard++;
        end
        s_arvalid = 1'b0;
        if (!fr) begin
            n_errors++;
            $display("FAIL %s_timeout: no AR handshake, expected one", tag);
            void'(exp_r_q.pop_front());
            return;
        end
        check_r(tag);
        s_rready = 1'b1;
        tick();
        s_rready = 1'b0;
        n_checks++;
        if (s_rvalid !== 1'b0 || s_arready !== 1'b1) begin
            n_errors++;
            $display("FAIL %s_rdone: rvalid=%b arready=%b, expected 0/1", tag, s_rvalid, s_arready);
        end
    endtask

    task automatic test_reset();
        RST = 1'b1;
        s_awvalid = 0; s_wvalid = 0; s_bready = 0; s_arvalid = 0; s_rready = 0;
        s_awaddr = '0; s_araddr = '0; s_wdata = '0; s_wstrb = '0;
        for (int c = 0; c < NUM_CH; c++) m_ch[c] = 8'h00;
        repeat (3) tick();
        n_checks++;
        if ({LED, s_rdata, s_bresp, s_rresp, s_bvalid, s_rvalid, s_awready, s_wready, s_arready} !== 73'd0) begin
            n_errors++;
            $display("FAIL reset_state: LED=%h rdata=%h bv=%b rv=%b awr=%b wr=%b arr=%b, expected all 0",
                     LED, s_rdata, s_bvalid, s_rvalid, s_awready, s_wready, s_arready);
        end
        RST = 1'b0;
        tick();
        n_checks++;
        if (s_awready !== 1'b1 || s_wready !== 1'b1 || s_arready !== 1'b1) begin
            n_errors++;
            $display("FAIL reset_ready: awr=%b wr=%b arr=%b, expected 1/1/1", s_awready, s_wready, s_arready);
        end
        read_txn(12'h008, "read_ch2_after_reset");
    endtask

    task automatic test_write_same_cycle();
        write_txn(12'h004, 32'h0000_00A5, 4'hF, 0, 3, "write_ch1_a5");
    endtask

    task automatic test_modes_w_first();
        write_txn(12'h000, 32'h0000_000F, 4'hF, 2, 0, "ch0_write_0f");
        write_txn(12'h010, 32'h0000_00F0, 4'hF, 2, 0, "ch0_set_f0");
        write_txn(12'h030, 32'hFFFF_FF3C, 4'hF, 1, 1, "ch0_toggle_3c");
        read_txn(12'h030, "read_ch0_alias");
    endtask

    task automatic test_strobe_and_errors();
        write_txn(12'h00C, 32'h0000_0077, 4'h1, 0, 0, "ch3_write_77");
        write_txn(12'h00C, 32'h0000_0011, 4'h0, 0, 0, "ch3_nostrobe");
        write_txn(12'h100, 32'h0000_00FF, 4'hF, 0, 0, "write_decode_err");
        read_txn(12'h100, "read_decode_err");
        read_txn(12'h02F, "read_ch3_clear_alias");
    endtask

    // Read and CLEAR commit on the same edge: read must see the pre-write value.
    task automatic test_read_during_commit();
        bit fa, fw, fr;
        write_txn(12'h004, 32'h0000_005A, 4'hF, 0, 0, "ch1_write_5a");
        push_read(12'h004);
        push_write(12'h024, 32'h0000_00FF, 4'hF);
        s_awaddr = 12'h024; s_wdata = 32'hFF; s_wstrb = 4'hF; s_awvalid = 1; s_wvalid = 1;
        s_araddr = 12'h004; s_arvalid = 1;
        fa = s_awready; fw = s_wready; fr = s_arready;
        tick();
        s_awvalid = 0; s_wvalid = 0; s_arvalid = 0;
        n_checks++;
        if (!(fa && fw && fr)) begin
            n_errors++;
            $display("FAIL concurrent_ready: awr=%b wr=%b arr=%b, expected 1/1/1", fa, fw, fr);
        end
        check_r("read_pre_clear");
        check_b("clear_ch1");
        s_bready = 1; s_rready = 1;
        tick();
        s_bready = 0; s_rready = 0;
    endtask

    task automatic test_reset_mid_txn();
        push_write(12'h008, 32'h0000_0033, 4'hF);
        s_awaddr = 12'h008; s_wdata = 32'h33; s_wstrb = 4'hF; s_awvalid = 1; s_wvalid = 1;
        tick();
        s_awvalid = 0; s_wvalid = 0;
        check_b("pre_reset_write");
        s_araddr = 12'h008; s_arvalid = 1; RST = 1;
        tick();
        for (int c = 0; c < NUM_CH; c++) m_ch[c] = 8'h00;
        n_checks++;
        if (s_bvalid !== 1'b0 || s_rvalid !== 1'b0 || LED !== 32'h0) begin
            n_errors++;
            $display("FAIL mid_reset: bvalid=%b rvalid=%b LED=%h, expected 0/0/0", s_bvalid, s_rvalid, LED);
        end
        RST = 0; s_arvalid = 0;
        tick();
        write_txn(12'h018, 32'h0000_0081, 4'hF, 0, 0, "post_reset_set_ch2");
        read_txn(12'h008, "post_reset_read_ch2");
    endtask

    initial begin
        test_reset();
        test_write_same_cycle();
        test_modes_w_first();
        test_strobe_and_errors();
        test_read_during_commit();
        test_reset_mid_txn();
        repeat (2) tick();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
